// File: rtl/fpga_ram_pkg.sv
// rtl/fpga_ram_pkg.sv - shared types and constants for the pipelined simple dual-port RAM
package fpga_ram_pkg;

    // What port B returns when it reads the word port A is writing in the same cycle
    typedef enum logic {
        RAM_READ_FIRST_E  = 1'b0,
        RAM_WRITE_FIRST_E = 1'b1
    } ram_collision_mode_t;

    localparam int RAM_MAX_READ_LATENCY_C = 3;

    function automatic bit ram_latency_legal(input int latency);
        return (latency >= 1) && (latency <= RAM_MAX_READ_LATENCY_C);
    endfunction

endpackage

// File: rtl/fpga_ram_array_be.sv
// rtl/fpga_ram_array_be.sv - byte-enable storage array with read-first registered read, no reset
module fpga_ram_array_be #(
    parameter int data_width_p    = 32,
    parameter int address_width_p = 10
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [data_width_p/8-1:0]    wr_byte_en,
    input  logic [address_width_p-1:0]   wr_addr,
    input  logic [data_width_p-1:0]      wr_data,
    input  logic                         rd_en,
    input  logic [address_width_p-1:0]   rd_addr,
    output logic [data_width_p-1:0]      rd_data
);

    localparam int bytes_lp = data_width_p / 8;
    localparam int depth_lp = 1 << address_width_p;

    logic [data_width_p-1:0] mem_q [depth_lp];
    logic [data_width_p-1:0] rd_data_q;
    logic [data_width_p-1:0] rd_data_d;

    // Byte-masked write; untouched bytes keep their stored value
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < bytes_lp; i++) begin
                if (wr_byte_en[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register loads only on a request so it holds the last word read
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Registered read sees the pre-write word, giving plain read-first behaviour
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fpga_ram_1c_1w_1r_pipe.sv
// rtl/fpga_ram_1c_1w_1r_pipe.sv - simple dual-port RAM with byte enables, read pipeline and collision counter
module fpga_ram_1c_1w_1r_pipe
    import fpga_ram_pkg::*;
#(
    parameter int                  data_width_p     = 32,
    parameter int                  address_width_p  = 10,
    parameter int                  read_latency_p   = 1,
    parameter ram_collision_mode_t collision_mode_p = RAM_WRITE_FIRST_E,
    parameter int                  counter_width_p  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         port_a_write_en,
    input  logic [data_width_p/8-1:0]    port_a_byte_en,
    input  logic [address_width_p-1:0]   port_a_address,
    input  logic [data_width_p-1:0]      port_a_data_in,
    input  logic                         port_b_read_en,
    input  logic [address_width_p-1:0]   port_b_address,
    output logic [data_width_p-1:0]      port_b_data_out,
    output logic                         port_b_valid,
    output logic [counter_width_p-1:0]   collision_count
);

    localparam int                   bytes_lp   = data_width_p / 8;
    localparam logic [counter_width_p-1:0] cnt_one_lp = 1;

    if (!ram_latency_legal(read_latency_p)) begin : g_bad_latency
        $fatal(1, "fpga_ram_1c_1w_1r_pipe: read_latency_p must be 1..%0d", RAM_MAX_READ_LATENCY_C);
    end
    if ((data_width_p % 8) != 0) begin : g_bad_width
        $fatal(1, "fpga_ram_1c_1w_1r_pipe: data_width_p must be a multiple of 8");
    end

    logic [data_width_p-1:0] array_rd_data;

    fpga_ram_array_be #(
        .data_width_p    (data_width_p),
        .address_width_p (address_width_p)
    ) u_array (
        .clk        (clk),
        .wr_en      (port_a_write_en),
        .wr_byte_en (port_a_byte_en),
        .wr_addr    (port_a_address),
        .wr_data    (port_a_data_in),
        .rd_en      (port_b_read_en),
        .rd_addr    (port_b_address),
        .rd_data    (array_rd_data)
    );

    logic collision;

    logic                       s1_valid_q,    s1_valid_d;
    logic                       s1_has_data_q, s1_has_data_d;
    logic                       s1_merge_q,    s1_merge_d;
    logic [bytes_lp-1:0]        s1_be_q,       s1_be_d;
    logic [data_width_p-1:0]    s1_wdata_q,    s1_wdata_d;
    logic [counter_width_p-1:0] count_q,       count_d;
    logic [data_width_p-1:0]    s1_data;

    // Stage k of the read pipeline; index 1 is the array register plus merge
    wire [read_latency_p:1]                   stg_valid;
    wire [read_latency_p:1][data_width_p-1:0] stg_data;

    // Same-address read and write with at least one byte actually written
    always_comb begin
        collision = port_a_write_en && port_b_read_en &&
                    (port_a_address == port_b_address) && (|port_a_byte_en);
    end

    // Merge info is captured with the read so the array itself stays read-first
    always_comb begin
        s1_valid_d    = port_b_read_en;
        s1_has_data_d = s1_has_data_q | port_b_read_en;
        s1_merge_d    = s1_merge_q;
        s1_be_d       = s1_be_q;
        s1_wdata_d    = s1_wdata_q;
        if (port_b_read_en) begin
            s1_merge_d = collision && (collision_mode_p == RAM_WRITE_FIRST_E);
            s1_be_d    = port_a_byte_en;
            s1_wdata_d = port_a_data_in;
        end
    end

    // Saturating collision counter
    always_comb begin
        count_d = count_q;
        if (collision && (count_q != {counter_width_p{1'b1}})) begin
            count_d = count_q + cnt_one_lp;
        end
    end

    // Stage-1 control, merge snapshot and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_has_data_q <= 1'b0;
            s1_merge_q    <= 1'b0;
            s1_be_q       <= '0;
            s1_wdata_q    <= '0;
            count_q       <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_has_data_q <= s1_has_data_d;
            s1_merge_q    <= s1_merge_d;
            s1_be_q       <= s1_be_d;
            s1_wdata_q    <= s1_wdata_d;
            count_q       <= count_d;
        end
    end

    // Write-first overlay: written bytes replace the pre-write word from the array
    always_comb begin
        s1_data = array_rd_data;
        for (int i = 0; i < bytes_lp; i++) begin
            if (s1_merge_q && s1_be_q[i]) begin
                s1_data[8*i +: 8] = s1_wdata_q[8*i +: 8];
            end
        end
    end

    assign stg_valid[1] = s1_valid_q;
    assign stg_data[1]  = s1_data;

    for (genvar k = 2; k <= read_latency_p; k++) begin : g_stage
        logic                    v_q, v_d;
        logic [data_width_p-1:0] d_q, d_d;

        // Data only advances with a valid beat so the output holds its last value
        always_comb begin
            v_d = stg_valid[k-1];
            d_d = d_q;
            if (stg_valid[k-1]) begin
                d_d = stg_data[k-1];
            end
        end

        // Pipeline register carrying {valid, data}
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign stg_valid[k] = v_q;
        assign stg_data[k]  = d_q;
    end

    // The unreset array register is masked until a read has happened since reset
    assign port_b_valid    = stg_valid[read_latency_p];
    assign port_b_data_out = s1_has_data_q ? stg_data[read_latency_p] : '0;
    assign collision_count = count_q;

endmodule

// File: tb/tb_fpga_ram_1c_1w_1r_pipe.sv
// tb/tb_fpga_ram_1c_1w_1r_pipe.sv - randomized scoreboard bench for three RAM configurations
module tb_fpga_ram_1c_1w_1r_pipe;
    import fpga_ram_pkg::*;

    localparam int N_INST = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [3:0]  a_be;
    logic [7:0]  a_addr;
    logic [31:0] a_din;
    logic        b_re;
    logic [7:0]  b_addr;

    logic [31:0] dout [N_INST];
    logic        vld  [N_INST];
    logic [15:0] cnt  [N_INST];
    logic [3:0]  cnt_small;

    always #5 clk = ~clk;

    fpga_ram_1c_1w_1r_pipe #(.data_width_p(32), .address_width_p(8), .read_latency_p(1),
        .collision_mode_p(RAM_WRITE_FIRST_E), .counter_width_p(16)) u_l1 (
        .clk(clk), .rst(rst), .port_a_write_en(a_we), .port_a_byte_en(a_be),
        .port_a_address(a_addr), .port_a_data_in(a_din), .port_b_read_en(b_re),
        .port_b_address(b_addr), .port_b_data_out(dout[0]), .port_b_valid(vld[0]),
        .collision_count(cnt[0]));

    fpga_ram_1c_1w_1r_pipe #(.data_width_p(32), .address_width_p(8), .read_latency_p(2),
        .collision_mode_p(RAM_READ_FIRST_E), .counter_width_p(4)) u_l2 (
        .clk(clk), .rst(rst), .port_a_write_en(a_we), .port_a_byte_en(a_be),
        .port_a_address(a_addr), .port_a_data_in(a_din), .port_b_read_en(b_re),
        .port_b_address(b_addr), .port_b_data_out(dout[1]), .port_b_valid(vld[1]),
        .collision_count(cnt_small));

    fpga_ram_1c_1w_1r_pipe #(.data_width_p(32), .address_width_p(8), .read_latency_p(3),
        .collision_mode_p(RAM_WRITE_FIRST_E), .counter_width_p(16)) u_l3 (
        .clk(clk), .rst(rst), .port_a_write_en(a_we), .port_a_byte_en(a_be),
        .port_a_address(a_addr), .port_a_data_in(a_din), .port_b_read_en(b_re),
        .port_b_address(b_addr), .port_b_data_out(dout[2]), .port_b_valid(vld[2]),
        .collision_count(cnt[2]));

    assign cnt[1] = {12'd0, cnt_small};

    int          lat  [N_INST] = '{1, 2, 3};
    bit          wf   [N_INST] = '{1'b1, 1'b0, 1'b1};
    int          cmax [N_INST] = '{65535, 15, 65535};

    logic [31:0] ref_mem [256];
    bit          exp_v   [N_INST][4];
    logic [31:0] exp_d   [N_INST][4];
    logic [31:0] last_d  [N_INST];
    int          ecnt    [N_INST];
    int          cyc;
    int          n_chk;
    int          n_err;
    int          stream_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_INST; i++) begin
            for (int s = 0; s < 4; s++) exp_v[i][s] = 1'b0;
            last_d[i] = 32'd0;
            ecnt[i]   = 0;
        end
    endtask

    task automatic compare_all();
        int  slot;
        bit  ev;
        slot = cyc % 4;
        for (int i = 0; i < N_INST; i++) begin
            ev = !rst && exp_v[i][slot];
            if (ev) last_d[i] = exp_d[i][slot];
            if (!rst) exp_v[i][slot] = 1'b0;
            check($sformatf("valid_l%0d", lat[i]), {31'd0, vld[i]}, {31'd0, ev});
            check($sformatf("data_l%0d", lat[i]), dout[i], last_d[i]);
            check($sformatf("count_l%0d", lat[i]), {16'd0, cnt[i]}, ecnt[i]);
        end
    endtask

    task automatic tick();
        logic [31:0] word;
        bit          col;
        int          slot;
        @(posedge clk);
        if (!rst) begin
            cyc++;
            if (b_re) begin
                col = a_we && (a_addr == b_addr) && (a_be != 4'd0);
                for (int i = 0; i < N_INST; i++) begin
                    word = ref_mem[b_addr];
                    if (col && wf[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (a_be[b]) word[8*b +: 8] = a_din[8*b +: 8];
                    end
                    slot = (cyc + lat[i] - 1) % 4;
                    exp_v[i][slot] = 1'b1;
                    exp_d[i][slot] = word;
                    if (col && ecnt[i] < cmax[i]) ecnt[i]++;
                end
            end
            if (a_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) ref_mem[a_addr][8*b +: 8] = a_din[8*b +: 8];
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input bit we, input bit [3:0] be, input bit [7:0] wa, input bit [31:0] wd,
                         input bit re, input bit [7:0] ra);
        a_we = we; a_be = be; a_addr = wa; a_din = wd;
        b_re = re; b_addr = ra;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 8'd0, 32'd0, 1'b0, 8'd0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; stream_pulses = 0;
        rst = 1'b1;
        a_we = 1'b0; a_be = 4'd0; a_addr = 8'd0; a_din = 32'd0; b_re = 1'b0; b_addr = 8'd0;
        clear_model();
        idle(2);
        rst = 1'b0;

        // Fill the whole array so every later read has a known expected word
        for (int a = 0; a < 256; a++) drive(1'b1, 4'hF, a[7:0], $urandom, 1'b0, 8'd0);

        // Basic write then read
        drive(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0);
        drive(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 8'd5);
        idle(4);

        // Byte enables
        drive(1'b1, 4'hF, 8'd7, 32'h11223344, 1'b0, 8'd0);
        drive(1'b1, 4'b0101, 8'd7, 32'hAABBCCDD, 1'b0, 8'd0);
        drive(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 8'd7);
        idle(4);
        check("byte_en_word", ref_mem[7], 32'h11BB33DD);

        // Collision in both modes
        drive(1'b1, 4'hF, 8'd3, 32'h0, 1'b0, 8'd0);
        drive(1'b1, 4'b0011, 8'd3, 32'hFFFFFFFF, 1'b1, 8'd3);
        idle(4);
        check("coll_wf_data", dout[0], 32'h0000FFFF);
        check("coll_rf_data", dout[1], 32'h00000000);
        check("coll_cnt_l1", {16'd0, cnt[0]}, 32'd1);
        check("coll_cnt_l2", {16'd0, cnt[1]}, 32'd1);

        // Streaming reads while port A writes an unrelated region
        for (int i = 0; i < 64; i++) begin
            drive($urandom_range(0, 1), 4'($urandom), 8'(128 + $urandom_range(0, 127)), $urandom,
                  1'b1, i[7:0]);
            stream_pulses += int'(vld[2]);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            stream_pulses += int'(vld[2]);
        end
        check("stream_pulses_l3", stream_pulses, 64);

        // Reset with reads in flight
        drive(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 8'd5);
        drive(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 8'd7);
        b_re = 1'b0;
        rst = 1'b1;
        clear_model();
        #1;
        compare_all();
        idle(2);
        rst = 1'b0;
        idle(5);
        drive(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 8'd5);
        idle(4);
        check("reread_after_reset", dout[2], 32'hDEADBEEF);

        // Counter saturation
        for (int i = 0; i < 20; i++)
            drive(1'b1, 4'($urandom_range(1, 15)), 8'd9, $urandom, 1'b1, 8'd9);
        idle(4);
        check("sat_cnt_w4", {16'd0, cnt[1]}, 32'd15);
        check("sat_cnt_w16", {16'd0, cnt[0]}, 32'd20);

        // Random mix over a small window to provoke collisions
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 1), 4'($urandom), 8'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), 8'($urandom_range(0, 15)));
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
